// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner with input resync, stability filter and per-frame snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (3 downward) at snapshot time.
module seven_seg_scanner #(
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [4:0] bcd3,
  input  logic [4:0] bcd2,
  input  logic [4:0] bcd1,
  input  logic [4:0] bcd0,
  input  logic       si,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = 20;
  typedef enum logic {BLANK, DRIVE} state_t;

  // word layout: {bcd3, bcd2, bcd1, bcd0, si}; digit k lives at [5k+1 +: 5]
  logic [20:0] raw, sync1, sync2, prev, filt;
  logic [3:0]  stab_cnt, stab_next;

  assign raw = {bcd3, bcd2, bcd1, bcd0, si};

  always_comb begin
    stab_next = 4'd1;
    if (sync2 == prev) stab_next = (stab_cnt == 4'hF) ? 4'hF : stab_cnt + 4'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stab_cnt <= '0;
      filt     <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      prev     <= sync2;
      stab_cnt <= stab_next;
      if (stab_next >= 4'(STABLE_CYCLES)) filt <= sync2;
    end
  end

  logic [3:0][4:0] snap_code, snap_load;
  logic            snap_si;
`ifdef LEADING_ZERO_BLANK_EN
  logic            lead;
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) snap_load[k] = filt[5*k+1 +: 5];
`ifdef LEADING_ZERO_BLANK_EN
    // 5'h0A decodes as blank; digit 0 is always shown
    lead = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      if (lead && snap_load[k] == 5'd0) snap_load[k] = 5'h0A;
      else                              lead = 1'b0;
    end
`endif
  end

  state_t           state, state_next;
  logic [1:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             frame_start;

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    cnt_next    = cnt + CNT_W'(1);
    frame_start = 1'b0;
    case (state)
      BLANK: if (cnt == CNT_W'(GUARD - 1)) begin
        state_next  = DRIVE;
        cnt_next    = '0;
        frame_start = (idx == 2'd0);
      end
      DRIVE: if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
        state_next = BLANK;
        cnt_next   = '0;
        idx_next   = idx + 2'd1;
      end
    endcase
  end

  function automatic logic [6:0] decode(input logic [4:0] c);
    case (c)
      5'd0:    decode = 7'b1000000;
      5'd1:    decode = 7'b1111001;
      5'd2:    decode = 7'b0100100;
      5'd3:    decode = 7'b0110000;
      5'd4:    decode = 7'b0011001;
      5'd5:    decode = 7'b0010010;
      5'd6:    decode = 7'b0000010;
      5'd7:    decode = 7'b1111000;
      5'd8:    decode = 7'b0000000;
      5'd9:    decode = 7'b0010000;
      5'h1F:   decode = 7'b1110111;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state     <= BLANK;
      idx       <= '0;
      cnt       <= '0;
      snap_code <= '0;
      snap_si   <= 1'b0;
      an        <= 4'hF;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      if (frame_start) begin
        snap_code <= snap_load;
        snap_si   <= filt[0];
      end
      // outputs follow the pre-edge state, one cycle behind the FSM
      an  <= (state == DRIVE) ? ~(4'b0001 << idx) : 4'hF;
      seg <= (state == DRIVE) ? decode(snap_code[idx]) : 7'h7F;
      dp  <= ~((state == DRIVE) && (idx == 2'd3) && snap_si);
    end
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Display back-end downstream of the step tracker.
- Consumes the four 5-bit digit codes (bcd3..bcd0) and the overflow flag (si), which originate in the step_clk domain.
- Resynchronises and filters them into sys_clk, snapshots them once per frame, and time-multiplexes a 4-digit common-anode seven-segment display.
- Inserts a guard interval between digits to suppress ghosting.

Parameters:
- REFRESH_DIV, 100000: sys_clk cycles each digit is driven (1 kHz/digit at 100 MHz); legal 2..2^20.
- GUARD, 4: sys_clk cycles all anodes are off between digits; legal 1..255.
- STABLE_CYCLES, 2: consecutive identical synchronised samples required before a new input value is accepted; legal 1..15.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge; the only clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on sys_clk).
- bcd3  in  5  digit code, leftmost digit (step_clk domain).
- bcd2  in  5  digit code.
- bcd1  in  5  digit code.
- bcd0  in  5  digit code, rightmost digit.
- si  in  1  step-count overflow flag (step_clk domain).
- an  out  4  anode enables, active-low; an[0] = rightmost digit.
- seg  out  7  segments, active-low; seg[6:0] = g,f,e,d,c,b,a.
- dp  out  1  decimal point, active-low.

Behaviour:
- Input path, stage 1: two-flop synchroniser on all 21 input bits.
- Input path, stage 2: stability filter. The filtered register loads the synchronised word only after that word has been identical for STABLE_CYCLES consecutive cycles. A change restarts the count. The counter saturates.
- Input path, stage 3: the display snapshot loads from the filtered register only on the BLANK->DRIVE transition for digit 0 (frame start). Values are never torn within a frame.
- FSM states: BLANK and DRIVE. Also kept: a digit index 0..3 and a cycle counter.
- BLANK: counts GUARD cycles, then moves to DRIVE with the counter cleared.
- DRIVE: counts REFRESH_DIV cycles, then moves to BLANK. The index increments mod 4 (3 wraps to 0).
- Frame length: 4*(GUARD+REFRESH_DIV) cycles.
- Outputs are registered from FSM state and index, so they lag the FSM by exactly 1 cycle.
- In BLANK: an=4'b1111, seg=7'b1111111, dp=1.
- In DRIVE for index k: an has only bit k low, and seg shows the decoded snapshot code for digit k.
- Decode, 0..9: standard patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
- Decode, 5'h1F: underscore, 1110111.
- Decode, 5'h0A..5'h1E: blank, 1111111.
- dp is 0 only while digit 3 is driven and snapshot si=1; otherwise dp=1.
- Reset (reset=0 at an edge): state=BLANK, index=0, counters=0, synchroniser/filter/snapshot=0, an=1111, seg=1111111, dp=1.
- Reset asserted mid-operation takes effect at that edge with no partial frame. After release, digit 0 is the first digit driven.
- Input change during the synchroniser/filter window: the previously accepted value remains displayed.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: at snapshot time, leading code-0 digits from digit 3 downward are replaced by blank. Stops at the first nonzero code (including 5'h1F). Digit 0 is never blanked.
- When undefined: all digits are displayed as decoded.

Test Plan:
- All cases use REFRESH_DIV=8, GUARD=2, STABLE_CYCLES=2.
- Reset/scan: reset=0 for 5 cycles -> an=1111, seg=1111111, dp=1. Release with bcd3..0=1,2,3,4 -> after settling, frames show an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001. Exactly 2 all-off cycles between digits; frame = 40 cycles.
- Codes: bcd1=5'h1F, bcd2=5'h0C -> digit1 seg=1110111, digit2 seg=1111111.
- Snapshot: change bcd0 4->7 while digit 2 is driven -> digit 0 still shows 4 until the next frame start, then 1111000. A 1-cycle glitch on bcd0 is never displayed.
- Overflow: si=1 with all bcd=9 -> dp=0 only during an=0111, dp=1 elsewhere.
- Mid-drive reset: reset=0 for 1 cycle during digit 2 -> next cycle an=1111, seg=1111111. Scan restarts at digit 0 with snapshot 0 (seg=1000000) until new inputs are accepted.
- With LEADING_ZERO_BLANK_EN, bcd3..0=0,0,4,2 -> digits 3 and 2 blank. With all inputs 0 -> only digit 0 shows 1000000.
